afifo_wr_arbiter: RTL and testbench

//   Round-robin burst arbiter sharing the write port of the async FIFO among NUM_REQ requesters.

---
 rtl/afifo_wr_arbiter.sv | 136 +++++++++++++
 tb/tb_afifo_wr_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/afifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port (write-clock domain).
// One requester owns the port for up to MAX_BURST beats; one bubble cycle per arbitration.
// Optional per-requester beat counters: define AFIFO_ARB_STATS_EN.
module afifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [$clog2(NUM_REQ)-1:0]      owner,
  output logic                            busy,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_wr_data,
  output logic [NUM_REQ*16-1:0]           stat_beats
);

  localparam int unsigned OW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]            state;
  logic [OW-1:0]         last_owner;
  logic [CW-1:0]         beat_cnt;
  logic [OW-1:0]         pick;
  logic [OW-1:0]         scan_idx;
  logic                  found;
  logic                  beat;
  logic [DATA_WIDTH-1:0] req_slice [NUM_REQ];

  // Unpack the flat request data bus into per-requester beats
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin scan: first set req starting just after last_owner, wrapping modulo NUM_REQ
  always_comb begin
    pick     = last_owner;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      scan_idx = OW'((32'(last_owner) + i) % NUM_REQ);
      if (!found && req[scan_idx]) begin
        pick  = scan_idx;
        found = 1'b1;
      end
    end
  end

  // A beat is accepted when the owner presents data and the FIFO has room
  always_comb begin
    busy = (state == BURST);
    beat = busy && req[owner] && !fifo_full;
  end

  // Grant follows the owner in BURST, masked while the FIFO is full
  always_comb begin
    gnt = '0;
    if (busy && !fifo_full) begin
      gnt[owner] = 1'b1;
    end
  end

  // Zero-latency write path; data forced to zero when not writing
  always_comb begin
    fifo_wr_en   = beat;
    fifo_wr_data = beat ? req_slice[owner] : '0;
  end

  // Arbitration FSM: IDLE picks a winner, BURST streams beats until limit or release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner      <= pick;
            last_owner <= pick;
            beat_cnt   <= '0;
            state      <= BURST;
          end
        end
        BURST: begin
          if (!req[owner]) begin
            state <= IDLE;
          end else if (beat) begin
            if (beat_cnt == CW'(MAX_BURST - 1)) begin
              state <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AFIFO_ARB_STATS_EN
  logic [15:0] stat_cnt [NUM_REQ];

  // Saturating per-requester beat counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        stat_cnt[i] <= '0;
      end
    end else if (beat && (stat_cnt[owner] != '1)) begin
      stat_cnt[owner] <= stat_cnt[owner] + 1'b1;
    end
  end

  // Pack counters onto the flat statistics bus
  always_comb begin
    stat_beats = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      stat_beats[i*16 +: 16] = stat_cnt[i];
    end
  end
`else
  assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Self-checking bench for afifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=4).
// Per-cycle vector table plus hand-written asynchronous-reset sequence; write data via scoreboard queue.
module tb_afifo_wr_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic [1:0]   owner;
  logic         busy;
  logic         fifo_full;
  logic         fifo_wr_en;
  logic [31:0]  fifo_wr_data;
  logic [63:0]  stat_beats;

  afifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(32),
    .MAX_BURST (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .owner       (owner),
    .busy        (busy),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .stat_beats  (stat_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic       we;
    logic       busy;
    logic [1:0] owner;
  } row_t;

  row_t            tbl[$];
  logic [31:0]     exp_q[$];
  int unsigned     k[4];
  int              checks;
  int              failures;

  function automatic logic [31:0] dval(int unsigned i, int unsigned n);
    return 32'hA0 + (i << 8) + n;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(logic rst, logic [3:0] rq, logic full, logic [3:0] g, logic we,
                     logic bz, logic [1:0] ow);
    row_t r;
    r.rst = rst; r.req = rq; r.full = full; r.gnt = g; r.we = we; r.busy = bz; r.owner = ow;
    tbl.push_back(r);
  endtask

  task automatic drive_data();
    for (int i = 0; i < 4; i++) begin
      req_data[32*i +: 32] = dval(i, k[i]);
    end
  endtask

  // Called at posedge+1: drive a row, check at negedge, return to posedge+1
  task automatic run_rows(int lo, int hi);
    for (int n = lo; n < hi; n++) begin
      row_t r;
      r = tbl[n];
      if (r.rst) begin
        for (int i = 0; i < 4; i++) k[i] = 0;
      end
      rst_n     = !r.rst;
      req       = r.req;
      fifo_full = r.full;
      drive_data();
      if (r.we) begin
        exp_q.push_back(dval(r.owner, k[r.owner]));
        k[r.owner]++;
      end
      @(negedge clk);
      chk($sformatf("gnt[%0d]", n),   64'(gnt),        64'(r.gnt));
      chk($sformatf("wr_en[%0d]", n), 64'(fifo_wr_en), 64'(r.we));
      chk($sformatf("busy[%0d]", n),  64'(busy),       64'(r.busy));
      chk($sformatf("owner[%0d]", n), 64'(owner),      64'(r.owner));
      chk($sformatf("no_full_wr[%0d]", n), 64'(fifo_wr_en && fifo_full), 64'(0));
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("unexpected_wr[%0d]", n), 64'(fifo_wr_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk($sformatf("wr_data[%0d]", n), 64'(fifo_wr_data), 64'(exp_q.pop_front()));
        end
      end else begin
        chk($sformatf("idle_data[%0d]", n), 64'(fifo_wr_data), 64'(0));
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int a, b, c, d;
    checks = 0; failures = 0;
    rst_n = 1'b0; req = '0; fifo_full = 1'b0; req_data = '0;
    for (int i = 0; i < 4; i++) k[i] = 0;

    // Scenario 1: single requester, back-to-back bursts with one bubble
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 2'd0);
    add(0, 4'b0001, 0, 4'b0000, 0, 0, 2'd0);
    for (int i = 0; i < 4; i++) add(0, 4'b0001, 0, 4'b0001, 1, 1, 2'd0);
    add(0, 4'b0001, 0, 4'b0000, 0, 0, 2'd0);
    for (int i = 0; i < 4; i++) add(0, 4'b0001, 0, 4'b0001, 1, 1, 2'd0);
    a = tbl.size();
    // Scenario 2: all requesting, rotation 0,1,2,3,0
    add(1, 4'b1111, 0, 4'b0000, 0, 0, 2'd0);
    add(0, 4'b1111, 0, 4'b0000, 0, 0, 2'd0);
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 4; i++) add(0, 4'b1111, 0, 4'(1 << o), 1, 1, 2'(o));
      add(0, 4'b1111, 0, 4'b0000, 0, 0, 2'(o));
    end
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 0, 4'b0001, 1, 1, 2'd0);
    b = tbl.size();
    // Scenario 3: owner 2 releases after 2 beats
    add(0, 4'b0100, 0, 4'b0000, 0, 0, 2'd0);
    for (int i = 0; i < 2; i++) add(0, 4'b0100, 0, 4'b0100, 1, 1, 2'd2);
    add(0, 4'b1011, 0, 4'b0100, 0, 1, 2'd2);
    add(0, 4'b1011, 0, 4'b0000, 0, 0, 2'd2);
    for (int i = 0; i < 4; i++) add(0, 4'b1011, 0, 4'b1000, 1, 1, 2'd3);
    add(0, 4'b1011, 0, 4'b0000, 0, 0, 2'd3);
    add(0, 4'b1011, 0, 4'b0001, 1, 1, 2'd0);
    // Scenario 4: FIFO full for 3 cycles after beat 0, burst still totals 4
    for (int i = 0; i < 3; i++) add(0, 4'b1011, 1, 4'b0000, 0, 1, 2'd0);
    for (int i = 0; i < 3; i++) add(0, 4'b1011, 0, 4'b0001, 1, 1, 2'd0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 2'd0);
    // Full during arbitration and first burst cycle, then release with FIFO not full
    add(0, 4'b0010, 1, 4'b0000, 0, 0, 2'd0);
    add(0, 4'b0010, 1, 4'b0000, 0, 1, 2'd1);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 2'd1);
    add(0, 4'b0000, 0, 4'b0010, 0, 1, 2'd1);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 2'd1);
    add(0, 4'b1111, 0, 4'b0000, 0, 0, 2'd1);
    add(0, 4'b1111, 0, 4'b0100, 1, 1, 2'd2);
    c = tbl.size();
    // After asynchronous reset requester 0 wins first
    add(0, 4'b1111, 0, 4'b0000, 0, 0, 2'd0);
    add(0, 4'b1111, 0, 4'b0001, 1, 1, 2'd0);
    add(0, 4'b0000, 0, 4'b0001, 0, 1, 2'd0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 2'd0);
    d = tbl.size();

    @(posedge clk);
    #1;
    run_rows(0, a);
`ifdef AFIFO_ARB_STATS_EN
    chk("stats_s1", stat_beats, {16'd0, 16'd0, 16'd0, 16'd8});
`else
    chk("stats_s1", stat_beats, 64'd0);
`endif
    run_rows(a, b);
`ifdef AFIFO_ARB_STATS_EN
    chk("stats_s2", stat_beats, {16'd4, 16'd4, 16'd4, 16'd8});
`else
    chk("stats_s2", stat_beats, 64'd0);
`endif
    run_rows(b, c);

    // Scenario 5: reset asserted between clock edges in the middle of owner 2's burst
    drive_data();
    #1;
    chk("pre_rst_gnt",   64'(gnt),          64'(4'b0100));
    chk("pre_rst_wr_en", 64'(fifo_wr_en),   64'(1));
    chk("pre_rst_data",  64'(fifo_wr_data), 64'(dval(2, k[2])));
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt",   64'(gnt),          64'(0));
    chk("async_rst_wr_en", 64'(fifo_wr_en),   64'(0));
    chk("async_rst_busy",  64'(busy),         64'(0));
    chk("async_rst_owner", 64'(owner),        64'(0));
    chk("async_rst_data",  64'(fifo_wr_data), 64'(0));
    chk("async_rst_stats", stat_beats,        64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) k[i] = 0;
    run_rows(c, d);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
